// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads DEPTH words, bubble-sorts them in place with one shared comparator, unloads ascending.
// Optional CMP_SORT_EARLY_EXIT_EN: leave SORT after the first pass that makes no swap.
module cmp_sort_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_CMP = PW'(DEPTH - 2);

    typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    idx_q, idx_d, pass_q, pass_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [PW-1:0]    idx_nx;
    logic [WIDTH-1:0] a, b;
    logic             lt, gt, eq, swap, pass_end, done;

    assign idx_nx   = idx_q + 1'b1;
    assign a        = mem_q[idx_q];
    assign b        = mem_q[idx_nx];
    assign lt       = a < b;
    assign gt       = a > b;
    assign eq       = a == b;
    // swap only on a clean gt so equal words keep input order
    assign swap     = {lt, eq, gt} == 3'b001;
    assign pass_end = idx_q == LAST_CMP - pass_q;

`ifdef CMP_SORT_EARLY_EXIT_EN
    logic swapped_q, swapped_d;
    assign swapped_d = (idx_q == '0 ? 1'b0 : swapped_q) | swap;
    assign done      = pass_end & ((pass_q == LAST_CMP) | ~swapped_d);
    always_ff @(posedge clk or posedge rst)
        if (rst) swapped_q <= 1'b0;
        else if (state_q == SORT) swapped_q <= swapped_d;
`else
    assign done = pass_end & (pass_q == LAST_CMP);
`endif

    assign in_ready  = state_q == LOAD;
    assign out_valid = state_q == UNLOAD;
    assign busy      = (state_q == SORT) | (state_q == UNLOAD);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        pass_d   = pass_q;
        mem_d    = mem_q;
        case (state_q)
            LOAD: if (in_valid) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d = wr_ptr_q == LAST_PTR ? '0 : wr_ptr_q + 1'b1;
                state_d  = wr_ptr_q == LAST_PTR ? SORT : LOAD;
            end
            SORT: begin
                if (swap) begin
                    mem_d[idx_q]  = b;
                    mem_d[idx_nx] = a;
                end
                idx_d   = pass_end ? '0 : idx_nx;
                pass_d  = done ? '0 : pass_end ? pass_q + 1'b1 : pass_q;
                state_d = done ? UNLOAD : SORT;
            end
            UNLOAD: if (out_ready) begin
                rd_ptr_d = rd_ptr_q == LAST_PTR ? '0 : rd_ptr_q + 1'b1;
                state_d  = rd_ptr_q == LAST_PTR ? LOAD : UNLOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idx_q    <= '0;
            pass_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            pass_q   <= pass_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl: directed blocks for cmp_sort_ctrl (WIDTH=4, DEPTH=4), honours CMP_SORT_EARLY_EXIT_EN.
module tb_cmp_sort_ctrl;
    logic       clk = 0, rst = 1;
    logic       in_valid = 0, out_ready = 0;
    logic [3:0] in_data = 0;
    logic       in_ready, out_valid, busy;
    logic [3:0] out_data;
    int         checks = 0, failures = 0;

`ifdef CMP_SORT_EARLY_EXIT_EN
    localparam bit EE = 1;
`else
    localparam bit EE = 0;
`endif

    cmp_sort_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [3:0] w [4]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1;
            in_data  = w[i];
            chk("load_ready", in_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 0;
        chk("sort_ready_low", in_ready, 0);
    endtask

    task automatic sort_wait(input int exp_cyc);
        int n = 0;
        while (!out_valid && n < 50) begin
            chk("sort_busy", busy, 1);
            n++;
            @(negedge clk);
        end
        chk("sort_cycles", n, exp_cyc);
    endtask

    task automatic unload(input logic [3:0] w [4]);
        for (int i = 0; i < 4; i++) begin
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, w[i]);
            chk("unload_busy", busy, 1);
            out_ready = 1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 0;
        end
        chk("done_busy", busy, 0);
        chk("done_in_ready", in_ready, 1);
        chk("done_out_valid", out_valid, 0);
    endtask

    task automatic block(input logic [3:0] wi [4], input logic [3:0] wo [4], input int cyc);
        load(wi);
        sort_wait(cyc);
        unload(wo);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 0;

        block('{1, 10, 15, 13}, '{1, 10, 13, 15}, EE ? 5 : 6);
        block('{0, 1, 2, 3},    '{0, 1, 2, 3},    EE ? 3 : 6);
        block('{13, 13, 12, 12}, '{12, 12, 13, 13}, 6);
        block('{15, 12, 10, 1}, '{1, 10, 12, 15}, 6);

        // stall the consumer and push input while unloading
        load('{10, 1, 15, 12});
        sort_wait(EE ? 5 : 6);
        in_valid = 1;
        in_data  = 7;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 1);
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 0;
        unload('{1, 10, 12, 15});

        // reset in the middle of SORT discards the block
        load('{1, 10, 15, 13});
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 0;
        block('{3, 2, 1, 0}, '{0, 1, 2, 3}, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
